// File: rtl/mcu_debug_arbiter.sv
// mcu_debug_arbiter: shares the MCU debug port between the serial debug
// controller (port 0) and the fast programmer (port 1).
// Round-robin arbitration, one MCU operation at a time, per-port responses,
// and PAUSE..RESUME/RESET ownership lock.
// Optional feature macro: DBG_ARB_TIMEOUT_EN enables the WAIT timeout
// counter (err=2). Without it, WAIT waits indefinitely for mcu_busy low.
module mcu_debug_arbiter #(
  parameter int unsigned CLK_RATE       = 50,
  parameter int unsigned TIMEOUT        = 200,
  parameter int unsigned TIMEOUT_CYCLES = CLK_RATE * 1000 * TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][2:0]  req_op,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][1:0]  req_size,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic             owner_lock,
  output logic             owner_id,
  input  logic             mcu_busy,
  input  logic [31:0]      d_rd,
  input  logic             error,
  output logic [31:0]      addr,
  output logic [31:0]      d_in,
  output logic [1:0]       mem_size,
  output logic             pause,
  output logic             resume,
  output logic             reset,
  output logic             reg_rd,
  output logic             reg_wr,
  output logic             mem_rd,
  output logic             mem_wr
);

  localparam logic [2:0] OP_PAUSE  = 3'd0;
  localparam logic [2:0] OP_RESUME = 3'd1;
  localparam logic [2:0] OP_RESET  = 3'd2;
  localparam logic [2:0] OP_REG_RD = 3'd3;
  localparam logic [2:0] OP_REG_WR = 3'd4;
  localparam logic [2:0] OP_MEM_RD = 3'd5;
  localparam logic [2:0] OP_MEM_WR = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MCU     = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

`ifdef DBG_ARB_TIMEOUT_EN
  localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        cur_port;
  logic [2:0]  cur_op;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        last_grant;
  logic [1:0]  err_code;
  logic        err_flag;
  logic [31:0] rdata_cap;
  logic        wait_first;
`ifdef DBG_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`endif

  logic [1:0]  eligible;
  logic        grant_any;
  logic        grant_port;
  logic        is_read;
  logic        done_err;

  // Eligible set and round-robin pick; a locked MCU only listens to its owner.
  always_comb begin
    eligible = req_valid;
    if (owner_lock) begin
      eligible = req_valid & (owner_id ? 2'b10 : 2'b01);
    end else begin
      eligible = req_valid;
    end
    grant_any = |eligible;
    if (eligible == 2'b11) begin
      grant_port = ~last_grant;
    end else begin
      grant_port = eligible[1];
    end
    is_read  = (cur_op == OP_REG_RD) || (cur_op == OP_MEM_RD);
    done_err = err_flag | error;
  end

  // Arbitration / issue / wait / response state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_port   <= 1'b0;
      cur_op     <= 3'd0;
      cur_addr   <= 32'd0;
      cur_wdata  <= 32'd0;
      cur_size   <= 2'd0;
      last_grant <= 1'b1;
      err_code   <= 2'd0;
      err_flag   <= 1'b0;
      rdata_cap  <= 32'd0;
      wait_first <= 1'b0;
`ifdef DBG_ARB_TIMEOUT_EN
      tmo_cnt    <= 32'd0;
`endif
      req_ready  <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 2'd0;
      owner_lock <= 1'b0;
      owner_id   <= 1'b0;
      addr       <= 32'd0;
      d_in       <= 32'd0;
      mem_size   <= 2'd0;
      pause      <= 1'b0;
      resume     <= 1'b0;
      reset      <= 1'b0;
      reg_rd     <= 1'b0;
      reg_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
    end else begin
      // Pulses default low every cycle.
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      pause     <= 1'b0;
      resume    <= 1'b0;
      reset     <= 1'b0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            req_ready[grant_port] <= 1'b1;
            cur_port   <= grant_port;
            cur_op     <= req_op[grant_port];
            cur_addr   <= req_addr[grant_port];
            cur_wdata  <= req_wdata[grant_port];
            cur_size   <= req_size[grant_port];
            last_grant <= grant_port;
            if (req_op[grant_port] == OP_RSVD) begin
              // Reserved op never reaches the MCU.
              err_code  <= ERR_ILLEGAL;
              rdata_cap <= 32'd0;
              state     <= ST_RESP;
            end else begin
              state <= ST_ISSUE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          case (cur_op)
            OP_PAUSE:  pause  <= 1'b1;
            OP_RESUME: resume <= 1'b1;
            OP_RESET:  reset  <= 1'b1;
            OP_REG_RD: reg_rd <= 1'b1;
            OP_REG_WR: reg_wr <= 1'b1;
            OP_MEM_RD: mem_rd <= 1'b1;
            OP_MEM_WR: mem_wr <= 1'b1;
            default:   pause  <= 1'b0;
          endcase
          addr       <= cur_addr;
          d_in       <= cur_wdata;
          mem_size   <= cur_size;
          err_flag   <= error;
          wait_first <= 1'b1;
`ifdef DBG_ARB_TIMEOUT_EN
          tmo_cnt    <= 32'd0;
`endif
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          wait_first <= 1'b0;
`ifdef DBG_ARB_TIMEOUT_EN
          if (tmo_cnt == TMO_LAST) begin
            // Timeout wins over a simultaneous busy fall.
            err_code  <= ERR_TIMEOUT;
            rdata_cap <= 32'd0;
            state     <= ST_RESP;
          end else if (!wait_first && !mcu_busy) begin
            err_code  <= done_err ? ERR_MCU : ERR_NONE;
            rdata_cap <= is_read ? d_rd : 32'd0;
            state     <= ST_RESP;
          end else begin
            tmo_cnt  <= tmo_cnt + 32'd1;
            err_flag <= done_err;
            state    <= ST_WAIT;
          end
`else
          // The first WAIT cycle ignores busy: the MCU has not reacted yet.
          if (!wait_first && !mcu_busy) begin
            err_code  <= done_err ? ERR_MCU : ERR_NONE;
            rdata_cap <= is_read ? d_rd : 32'd0;
            state     <= ST_RESP;
          end else begin
            err_flag <= done_err;
            state    <= ST_WAIT;
          end
`endif
        end

        ST_RESP: begin
          rsp_valid[cur_port] <= 1'b1;
          rsp_rdata           <= rdata_cap;
          rsp_err             <= err_code;
          // Ownership only changes on ops that reached the MCU (err 0/1).
          if (err_code <= ERR_MCU) begin
            case (cur_op)
              OP_PAUSE: begin
                if (!owner_lock) begin
                  owner_lock <= 1'b1;
                  owner_id   <= cur_port;
                end else begin
                  owner_lock <= owner_lock;
                end
              end
              OP_RESUME, OP_RESET: begin
                if (owner_lock && (owner_id == cur_port)) begin
                  owner_lock <= 1'b0;
                end else begin
                  owner_lock <= owner_lock;
                end
              end
              default: owner_lock <= owner_lock;
            endcase
          end else begin
            owner_lock <= owner_lock;
          end
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_debug_arbiter.sv
// Scoreboard bench for mcu_debug_arbiter: directed requests push expected
// responses; a monitor pops and compares on every rsp_valid pulse.
// Timeout scenario runs only when DBG_ARB_TIMEOUT_EN is defined.
module tb_mcu_debug_arbiter;

  localparam logic [2:0] OP_PAUSE  = 3'd0;
  localparam logic [2:0] OP_RESUME = 3'd1;
  localparam logic [2:0] OP_REG_RD = 3'd3;
  localparam logic [2:0] OP_REG_WR = 3'd4;
  localparam logic [2:0] OP_MEM_RD = 3'd5;
  localparam logic [2:0] OP_MEM_WR = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  logic             clk;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][1:0]  req_size;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic [1:0]       rsp_err;
  logic             owner_lock;
  logic             owner_id;
  logic             mcu_busy;
  logic [31:0]      d_rd;
  logic             error;
  logic [31:0]      addr;
  logic [31:0]      d_in;
  logic [1:0]       mem_size;
  logic pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr;
  logic [6:0]       strb;

  assign strb = {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr};

  mcu_debug_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .owner_lock(owner_lock), .owner_id(owner_id),
    .mcu_busy(mcu_busy), .d_rd(d_rd), .error(error),
    .addr(addr), .d_in(d_in), .mem_size(mem_size),
    .pause(pause), .resume(resume), .reset(reset), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rsp_cyc = 0;
  int n_strobes = 0;
  int n_regrd = 0;
  int busy_len = 0;
  int busy_left = 0;
  bit stuck_busy = 1'b0;
  bit err_arm = 1'b0;
  bit err_now = 1'b0;
  int acc0, acc1, s0, r0, seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic p, input logic [31:0] rd, input logic [1:0] e);
    exp_t x;
    x.port  = p;
    x.rdata = rd;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic send(input logic p, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz, output int acc);
    int n;
    @(posedge clk); #1;
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_addr[p]  = a;
    req_wdata[p] = wd;
    req_size[p]  = sz;
    n   = 0;
    acc = -1;
    while (acc < 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (req_ready[p]) acc = cyc;
    end
    if (acc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_p%0d: no req_ready after %0d cycles, required a pulse", p, n);
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    req_addr[p]  = 32'hFFFF_FFFF;
    req_wdata[p] = 32'hFFFF_FFFF;
    req_op[p]    = 3'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_wait: %0d responses missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every response pulse is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        last_rsp_cyc = cyc;
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b, required none", rsp_valid);
        end else begin
          mon_x = sb.pop_front();
          if (rsp_valid !== (mon_x.port ? 2'b10 : 2'b01) ||
              rsp_rdata !== mon_x.rdata || rsp_err !== mon_x.err) begin
            n_errors++;
            $display("FAIL rsp: got valid=%b rdata=0x%0h err=%0d, required port=%0d rdata=0x%0h err=%0d",
                     rsp_valid, rsp_rdata, rsp_err, mon_x.port, mon_x.rdata, mon_x.err);
          end
        end
      end
    end
  end

  // MCU model: busy for busy_len cycles after a strobe, optional error pulse.
  initial begin
    mcu_busy = 1'b0;
    error    = 1'b0;
    forever begin
      @(negedge clk);
      if (strb != 7'd0) begin
        n_strobes++;
        if (reg_rd) n_regrd++;
        busy_left = busy_len;
        err_now   = err_arm;
        err_arm   = 1'b0;
      end
      @(posedge clk); #1;
      mcu_busy = stuck_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
      error   = err_now;
      err_now = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_strobes"},   32'(strb), 32'd0);
    chk({tag, "_addr"},      addr, 32'd0);
    chk({tag, "_d_in"},      d_in, 32'd0);
    chk({tag, "_mem_size"},  32'(mem_size), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_lock"},      32'({owner_lock, owner_id}), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    d_rd      = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Simultaneous MEM_WR after reset: port 0 first, next accept at T+5.
    busy_len = 0;
    expect_rsp(1'b0, 32'd0, 2'd0);
    expect_rsp(1'b1, 32'd0, 2'd0);
    fork
      send(1'b0, OP_MEM_WR, 32'd100, 32'h11, 2'd2, acc0);
      send(1'b1, OP_MEM_WR, 32'd200, 32'h22, 2'd2, acc1);
    join
    wait_idle();
    chk("tie1_gap", 32'(acc1 - acc0), 32'd5);
    chk("lat_busy0", 32'(last_rsp_cyc - acc1), 32'd4);

    // Port 0 REG_RD with busy for 3 cycles.
    busy_len = 3;
    d_rd     = 32'hDEAD_BEEF;
    r0       = n_regrd;
    expect_rsp(1'b0, 32'hDEAD_BEEF, 2'd0);
    send(1'b0, OP_REG_RD, 32'd5, 32'd0, 2'd2, acc0);
    @(negedge clk);
    chk("regrd_strobe", 32'(strb), 32'b0001000);
    chk("regrd_strobe_cyc", 32'(cyc - acc0), 32'd1);
    chk("regrd_addr", addr, 32'd5);
    @(negedge clk);
    chk("regrd_strobe_off", 32'(strb), 32'd0);
    wait_idle();
    d_rd = 32'd0;
    chk("regrd_pulses", 32'(n_regrd - r0), 32'd1);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Tie again: last grant was port 0, so port 1 goes first.
    busy_len = 1;
    expect_rsp(1'b1, 32'd0, 2'd0);
    expect_rsp(1'b0, 32'd0, 2'd0);
    fork
      send(1'b0, OP_MEM_WR, 32'd300, 32'h33, 2'd1, acc0);
      send(1'b1, OP_MEM_WR, 32'd400, 32'h44, 2'd1, acc1);
    join
    wait_idle();
    chk("tie2_order", 32'(acc0 > acc1), 32'd1);

    // Reserved op: response at T+1, no strobe.
    s0 = n_strobes;
    expect_rsp(1'b0, 32'd0, 2'd3);
    send(1'b0, OP_RSVD, 32'd0, 32'd0, 2'd0, acc0);
    wait_idle();
    chk("ill_lat", 32'(last_rsp_cyc - acc0), 32'd1);
    repeat (3) @(negedge clk);
    chk("ill_nostrobe", 32'(n_strobes - s0), 32'd0);

    // Port 1 PAUSE locks; port 0 stalls until port 1 RESUME.
    busy_len = 2;
    expect_rsp(1'b1, 32'd0, 2'd0);
    send(1'b1, OP_PAUSE, 32'd0, 32'd0, 2'd0, acc1);
    wait_idle();
    chk("pause_lock", 32'({owner_lock, owner_id}), 32'd3);
    d_rd = 32'h1234_5678;
    expect_rsp(1'b1, 32'd0, 2'd0);
    expect_rsp(1'b0, 32'h1234_5678, 2'd0);
    fork
      send(1'b0, OP_MEM_RD, 32'h80, 32'd0, 2'd2, acc0);
      begin
        seen = 0;
        repeat (12) begin
          @(negedge clk);
          if (req_ready[0]) seen = 1;
        end
        chk("lock_stall", 32'(seen), 32'd0);
        chk("lock_held", 32'({owner_lock, owner_id}), 32'd3);
        send(1'b1, OP_RESUME, 32'd0, 32'd0, 2'd0, acc1);
      end
    join
    wait_idle();
    d_rd = 32'd0;
    chk("resume_unlock", 32'(owner_lock), 32'd0);
    chk("resume_order", 32'(acc0 > acc1), 32'd1);

    // MCU error during WAIT of a MEM_WR while port 0 owns the lock.
    expect_rsp(1'b0, 32'd0, 2'd0);
    send(1'b0, OP_PAUSE, 32'd0, 32'd0, 2'd0, acc0);
    wait_idle();
    err_arm  = 1'b1;
    busy_len = 1;
    expect_rsp(1'b0, 32'd0, 2'd1);
    send(1'b0, OP_MEM_WR, 32'h40, 32'h55, 2'd2, acc0);
    wait_idle();
    chk("err_lock_kept", 32'({owner_lock, owner_id}), 32'd2);
    expect_rsp(1'b0, 32'd0, 2'd0);
    send(1'b0, OP_RESUME, 32'd0, 32'd0, 2'd0, acc0);
    wait_idle();
    chk("err_unlock", 32'(owner_lock), 32'd0);

`ifdef DBG_ARB_TIMEOUT_EN
    // Stuck busy: err 2 sixteen cycles after WAIT entry, then recovery.
    stuck_busy = 1'b1;
    d_rd       = 32'hAAAA_5555;
    expect_rsp(1'b0, 32'd0, 2'd2);
    send(1'b0, OP_REG_RD, 32'd9, 32'd0, 2'd0, acc0);
    wait_idle();
    chk("tmo_lat", 32'(last_rsp_cyc - acc0), 32'd18);
    stuck_busy = 1'b0;
    busy_len   = 0;
    d_rd       = 32'd0;
    expect_rsp(1'b1, 32'd0, 2'd0);
    send(1'b1, OP_REG_WR, 32'd9, 32'd1, 2'd0, acc1);
    wait_idle();
`endif

    // Reset asserted during WAIT: everything clears, no response.
    busy_len = 0;
    expect_rsp(1'b1, 32'd0, 2'd0);
    send(1'b1, OP_PAUSE, 32'd0, 32'd0, 2'd0, acc1);
    wait_idle();
    chk("pre_rst_lock", 32'({owner_lock, owner_id}), 32'd3);
    stuck_busy = 1'b1;
    send(1'b1, OP_REG_RD, 32'h77, 32'h99, 2'd3, acc1);
    repeat (3) @(posedge clk);
    #1;
    reset_n    = 1'b0;
    stuck_busy = 1'b0;
    busy_left  = 0;
    @(negedge clk);
    chk_reset_outputs("midop_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Port 0 is served normally after the abort.
    expect_rsp(1'b0, 32'd0, 2'd0);
    send(1'b0, OP_REG_WR, 32'd3, 32'h5A, 2'd0, acc0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
